// File: rtl/param_wb_dcache.sv
// param_wb_dcache: direct-mapped, write-back, write-allocate data cache with
// a ready handshake, whole-cache flush and saturating hit/miss counters.
module param_wb_dcache #(
  parameter int WORD_SIZE      = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic [WORD_SIZE-1:0]  hit_count,
  output logic [WORD_SIZE-1:0]  miss_count
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;
  state_t                r_state, w_next;
  logic [WORD_SIZE-1:0]  r_data [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]      r_tag [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid, r_dirty;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata, r_hit, r_miss;
  logic                  r_write, r_refilled;
  logic [OFF_W-1:0]      r_word;
  logic [IDX_W-1:0]      r_fptr;
  logic [OFF_W-1:0]      w_off;
  logic [IDX_W-1:0]      w_idx, w_line;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit, w_last_word, w_last_line, w_line_clean;
  assign w_off        = r_addr[OFF_W-1:0];
  assign w_idx        = r_addr[OFF_W +: IDX_W];
  assign w_tag        = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last_word  = &r_word;
  assign w_last_line  = &r_fptr;
  assign w_line_clean = !(r_valid[r_fptr] && r_dirty[r_fptr]);
  // Flush walks lines by pointer; normal misses use the request's index.
  assign w_line       = (r_state == FLUSH_SCAN || r_state == FLUSH_WB) ? r_fptr : w_idx;
  assign cpu_rdata    = cpu_ready ? r_data[{w_idx, w_off}] : '0;
  assign hit_count    = r_hit;
  assign miss_count   = r_miss;

  always_comb begin
    w_next     = r_state;
    cpu_ready  = 1'b0;
    flush_done = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (r_state)
      IDLE: w_next = flush_req ? FLUSH_SCAN : cpu_req ? COMPARE : IDLE;
      COMPARE: begin
        cpu_ready = w_hit;
        w_next    = w_hit ? IDLE : r_dirty[w_idx] ? WRITEBACK : REFILL;
      end
      WRITEBACK, FLUSH_WB: begin
        mem_write = 1'b1;
        mem_addr  = {r_tag[w_line], w_line, r_word};
        mem_wdata = r_data[{w_line, r_word}];
        if (mem_ack && w_last_word) w_next = (r_state == WRITEBACK) ? REFILL : FLUSH_SCAN;
      end
      REFILL: begin
        mem_read = 1'b1;
        mem_addr = {w_tag, w_idx, r_word};
        if (mem_ack && w_last_word) w_next = COMPARE;
      end
      FLUSH_SCAN: begin
        flush_done = w_line_clean && w_last_line;
        w_next     = !w_line_clean ? FLUSH_WB : w_last_line ? IDLE : FLUSH_SCAN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_refilled <= 1'b0;
      r_word     <= '0;
      r_fptr     <= '0;
      r_hit      <= '0;
      r_miss     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:
          if (flush_req) r_fptr <= '0;
          else if (cpu_req) begin
            r_addr     <= cpu_addr;
            r_wdata    <= cpu_wdata;
            r_write    <= cpu_write;
            r_refilled <= 1'b0;
          end
        COMPARE:
          if (w_hit) begin
            if (r_write) r_dirty[w_idx] <= 1'b1;
            // The completing COMPARE after a refill is part of the miss, not a hit.
            if (!r_refilled && !(&r_hit)) r_hit <= r_hit + 1'b1;
          end else if (!(&r_miss)) r_miss <= r_miss + 1'b1;
        WRITEBACK: if (mem_ack) r_word <= r_word + 1'b1;
        REFILL:
          if (mem_ack) begin
            r_word <= r_word + 1'b1;
            if (w_last_word) begin
              r_valid[w_idx] <= 1'b1;
              r_dirty[w_idx] <= 1'b0;
              r_refilled     <= 1'b1;
            end
          end
        FLUSH_SCAN:
          if (w_line_clean) begin
            r_valid[r_fptr] <= 1'b0;
            r_fptr          <= r_fptr + 1'b1;
          end
        FLUSH_WB:
          if (mem_ack) begin
            r_word <= r_word + 1'b1;
            // Line becomes clean; the scan then invalidates it and moves on.
            if (w_last_word) begin
              r_valid[r_fptr] <= 1'b0;
              r_dirty[r_fptr] <= 1'b0;
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == COMPARE && w_hit && r_write) r_data[{w_idx, w_off}] <= r_wdata;
    if (r_state == REFILL && mem_ack) r_data[{w_idx, r_word}] <= mem_rdata;
    if (r_state == REFILL && mem_ack && w_last_word) r_tag[w_idx] <= w_tag;
  end
endmodule

// File: tb/tb_param_wb_dcache.sv
// tb_param_wb_dcache: directed and random accesses against a flat-memory
// reference with a direct-mapped tag model; a narrow instance checks counter saturation.
module tb_param_wb_dcache;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_write = 1'b0, flush_req = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
  logic        cpu_ready, flush_done, mem_read, mem_write, mem_ack;
  logic        s_req = 1'b0;
  logic [7:0]  s_addr = '0, s_maddr;
  logic [3:0]  s_rdata, s_mwdata, s_mrdata, s_hit, s_miss;
  logic        s_ready, s_fdone, s_mr, s_mw, s_ack;

  always #5 clk = ~clk;

  param_wb_dcache #(.WORD_SIZE(16), .ADDR_WIDTH(16), .NUM_LINES(4), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush_req(flush_req), .flush_done(flush_done), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count));

  param_wb_dcache #(.WORD_SIZE(4), .ADDR_WIDTH(8), .NUM_LINES(2), .WORDS_PER_LINE(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .cpu_req(s_req), .cpu_write(1'b0),
    .cpu_addr(s_addr), .cpu_wdata(4'h0), .cpu_rdata(s_rdata), .cpu_ready(s_ready),
    .flush_req(1'b0), .flush_done(s_fdone), .mem_read(s_mr), .mem_write(s_mw),
    .mem_addr(s_maddr), .mem_wdata(s_mwdata), .mem_rdata(s_mrdata), .mem_ack(s_ack),
    .hit_count(s_hit), .miss_count(s_miss));

  int          checks = 0, errors = 0;
  int          ack_lat = 2, cnt = 0;
  logic        lg_w[$];
  logic [15:0] lg_a[$], lg_d[$];
  logic [15:0] rmem [int];
  logic        m_valid [4], m_dirty [4];
  logic [11:0] m_tag [4];
  int          m_hit, m_miss;

  // Backing memory is the initial pattern overlaid by every logged write.
  function automatic logic [15:0] bread(input logic [15:0] a);
    for (int i = lg_a.size() - 1; i >= 0; i--) if (lg_w[i] && lg_a[i] == a) return lg_d[i];
    return 16'h1000 + a;
  endfunction

  function automatic logic [15:0] rget(input logic [15:0] a);
    return rmem.exists(int'(a)) ? rmem[int'(a)] : 16'h1000 + a;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ack   <= 1'b0;
      mem_rdata <= '0;
      cnt       <= 0;
    end else begin
      mem_ack <= 1'b0;
      if ((mem_read || mem_write) && !mem_ack) begin
        if (cnt >= ack_lat) begin
          mem_ack <= 1'b1;
          cnt     <= 0;
          lg_w.push_back(mem_write);
          lg_a.push_back(mem_addr);
          lg_d.push_back(mem_write ? mem_wdata : bread(mem_addr));
          if (!mem_write) mem_rdata <= bread(mem_addr);
        end else cnt <= cnt + 1;
      end else cnt <= 0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_ack    <= 1'b0;
      s_mrdata <= '0;
    end else begin
      s_ack    <= (s_mr || s_mw) && !s_ack;
      s_mrdata <= s_maddr[3:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hit  = 0;
    m_miss = 0;
  endtask

  function automatic int model_flush();
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_dirty[i]) n++;
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    return n;
  endfunction

  task automatic model_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                              output logic [15:0] erd, output int ex);
    int idx = int'(a[3:2]);
    erd = rget(a);
    if (m_valid[idx] && m_tag[idx] == a[15:4]) begin
      ex = 0;
      if (m_hit < 65535) m_hit++;
    end else begin
      ex = m_dirty[idx] ? 8 : 4;
      if (m_miss < 65535) m_miss++;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[15:4];
    end
    if (w) begin
      m_dirty[idx]   = 1'b1;
      rmem[int'(a)] = d;
    end
  endtask

  task automatic wait_ready(output logic got, output logic [15:0] rd, output int lat);
    got = 1'b0;
    rd  = '0;
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) begin
        got = 1'b1;
        rd  = cpu_rdata;
        break;
      end
    end
  endtask

  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           input string tag, output logic [15:0] rd, output int lat);
    logic [15:0] erd;
    int          ex, n0;
    logic        got;
    model_access(w, a, d, erd, ex);
    n0        = lg_a.size();
    cpu_req   = 1'b1;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
    wait_ready(got, rd, lat);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk({tag, " ready"}, 32'(got), 32'd1);
    if (!w) chk({tag, " rdata"}, 32'(rd), 32'(erd));
    chk({tag, " traffic"}, 32'(lg_a.size() - n0), 32'(ex));
    chk({tag, " hits"}, 32'(hit_count), 32'(m_hit));
    chk({tag, " misses"}, 32'(miss_count), 32'(m_miss));
  endtask

  task automatic do_flush(input string tag);
    int   nd, n0;
    logic got = 1'b0;
    nd        = model_flush();
    n0        = lg_a.size();
    flush_req = 1'b1;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin
      @(negedge clk);
      if (flush_done) got = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " done"}, 32'(got), 32'd1);
    chk({tag, " traffic"}, 32'(lg_a.size() - n0), 32'(4 * nd));
  endtask

  initial begin
    logic [15:0] rd, erd, ra;
    int          lat, ex, nd, n, n0;
    logic        got;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(cpu_ready), 32'd0);
    chk("reset strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("reset flush_done", 32'(flush_done), 32'd0);
    chk("reset counters", 32'({hit_count, miss_count}), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    ack_lat = 2;
    do_access(1'b0, 16'h0005, 16'h0, "t1", rd, lat);
    chk("t1 value", 32'(rd), 32'h1005);
    n = lg_a.size();
    for (int k = 0; k < 4; k++) begin
      chk("t1 refill addr", 32'(lg_a[n-4+k]), 32'(4 + k));
      chk("t1 refill dir", 32'(lg_w[n-4+k]), 32'd0);
    end

    do_access(1'b0, 16'h0006, 16'h0, "t2", rd, lat);
    chk("t2 latency", 32'(lat), 32'd2);
    chk("t2 value", 32'(rd), 32'h1006);

    do_access(1'b1, 16'h0005, 16'hBEEF, "t3 store", rd, lat);
    do_access(1'b0, 16'h0015, 16'h0, "t3 load", rd, lat);
    n = lg_a.size();
    for (int k = 0; k < 4; k++) begin
      chk("t3 wb addr", 32'(lg_a[n-8+k]), 32'(4 + k));
      chk("t3 wb dir", 32'(lg_w[n-8+k]), 32'd1);
      chk("t3 refill addr", 32'(lg_a[n-4+k]), 32'(16'h14 + k));
      chk("t3 refill dir", 32'(lg_w[n-4+k]), 32'd0);
    end
    chk("t3 wb data", 32'(lg_d[n-7]), 32'hBEEF);

    do_access(1'b1, 16'h0020, 16'h1234, "t4 store", rd, lat);
    nd = model_flush();
    model_access(1'b0, 16'h0015, 16'h0, erd, ex);
    n0        = lg_a.size();
    flush_req = 1'b1;
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 16'h0015;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      chk("t4 no early ready", 32'(cpu_ready), 32'd0);
      if (flush_done) got = 1'b1;
    end
    chk("t4 flush_done", 32'(got), 32'd1);
    chk("t4 wb count", 32'(lg_a.size() - n0), 32'(4 * nd));
    chk("t4 wb data", 32'(bread(16'h0020)), 32'h1234);
    n0 = lg_a.size();
    wait_ready(got, rd, lat);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk("t4 ready", 32'(got), 32'd1);
    chk("t4 rdata", 32'(rd), 32'(erd));
    chk("t4 refill count", 32'(lg_a.size() - n0), 32'(ex));
    chk("t4 misses", 32'(miss_count), 32'(m_miss));

    for (int i = 0; i < 150; i++) begin
      ack_lat = $urandom_range(0, 2);
      ra      = 16'($urandom_range(0, 63));
      do_access(1'($urandom_range(0, 1)), ra, 16'($urandom), "rand", rd, lat);
    end
    do_flush("rand flush");
    for (int a = 0; a < 64; a++) chk("mem after flush", 32'(bread(16'(a))), 32'(rget(16'(a))));

    ack_lat   = 2;
    cpu_req   = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 16'h0030;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (mem_read && mem_addr[1:0] == 2'd2) got = 1'b1;
    end
    chk("t6 reached word2", 32'(got), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 mem_read async", 32'(mem_read), 32'd0);
    chk("t6 counters", 32'({hit_count, miss_count}), 32'd0);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    do_access(1'b0, 16'h0030, 16'h0, "t6", rd, lat);
    chk("t6 miss_count", 32'(miss_count), 32'd1);

    for (int k = 0; k < 20; k++) begin
      s_addr = 8'(k * 4);
      s_req  = 1'b1;
      got    = 1'b0;
      rd     = '0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk);
        if (s_ready) begin
          got = 1'b1;
          rd  = 16'(s_rdata);
        end
      end
      @(posedge clk);
      #1;
      s_req = 1'b0;
      chk("t5 ready", 32'(got), 32'd1);
      chk("t5 rdata", 32'(rd), 32'((k * 4) % 16));
      chk("t5 miss sat", 32'(s_miss), 32'((k + 1 > 15) ? 15 : k + 1));
    end
    chk("t5 hits", 32'(s_hit), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
